// File: rtl/pc_pkg.sv
// Shared types, default vectors and alignment helper for the program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    // Only the two low address bits matter for IALIGN of 2 or 4.
    function automatic logic is_misaligned(input logic [1:0] low_bits, input int unsigned ialign);
        return (ialign == 2) ? low_bits[0] : (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter, cleared by asynchronous active-low reset.
module perf_counter #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // NOTE: state registers use non-blocking assignment and the async-reset template so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, prioritised next-PC selection,
// misaligned-redirect trapping with EPC capture, and cycle/instret counters.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned       CNT_WIDTH    = 64,
    parameter int unsigned       IALIGN       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [WIDTH-1:0]     branch_target,
    input  logic                 trap,
    input  logic                 halt,
    output logic [WIDTH-1:0]     pc_out,
    output logic [WIDTH-1:0]     pc_plus4,
    output logic                 pc_valid,
    output logic                 misaligned,
    output logic [WIDTH-1:0]     epc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    pc_state_t        state;
    logic [WIDTH-1:0] pc_next;
    logic             take_trap;
    logic             fault;
    logic             retire;

    assign pc_plus4 = pc_out + WIDTH'(4);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_next   = pc_out;
        take_trap = 1'b0;
        fault     = 1'b0;
        retire    = 1'b0;
        if (state == RUN && !halt) begin
            if (trap) begin
                take_trap = 1'b1;
                pc_next   = TRAP_VECTOR;
            end else if (!stall && branch_taken) begin
                if (is_misaligned(branch_target[1:0], IALIGN)) begin
                    fault   = 1'b1;
                    pc_next = TRAP_VECTOR;
                end else begin
                    retire  = 1'b1;
                    pc_next = branch_target;
                end
            end else if (!stall) begin
                retire  = 1'b1;
                pc_next = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc_out     <= RESET_VECTOR;
            pc_valid   <= 1'b0;
            misaligned <= 1'b0;
            halted     <= 1'b0;
            epc        <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (halt) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                default: ;
            endcase
            pc_out     <= pc_next;
            misaligned <= fault;
            if (take_trap || fault) begin
                epc <= pc_out;
            end
        end
    end

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (state != HALT),
        .count (cycle_count)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instret_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (instret_count)
    );

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench: two configurations (32-bit/IALIGN 4 and 8-bit/4-bit counters/IALIGN 2)
// compared every cycle against a behavioural model, plus hand-computed directed expectations.
module tb_pc_gen_unit;

    typedef struct {
        bit          running;
        bit          stopped;
        bit          mis;
        logic [63:0] pc;
        logic [63:0] epc;
        logic [63:0] cyc;
        logic [63:0] ret;
    } mdl_t;

    logic clk;
    logic rst_n;

    logic        a_stall, a_br, a_trap, a_halt;
    logic [31:0] a_tgt, a_pc, a_pc4, a_epc;
    logic        a_valid, a_mis, a_halted;
    logic [63:0] a_cyc, a_ret;

    logic        b_stall, b_br, b_trap, b_halt;
    logic [7:0]  b_tgt, b_pc, b_pc4, b_epc;
    logic        b_valid, b_mis, b_halted;
    logic [3:0]  b_cyc, b_ret;

    mdl_t ma, mb;
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_gen_unit u_dut_a (
        .clk           (clk),
        .reset         (rst_n),
        .stall         (a_stall),
        .branch_taken  (a_br),
        .branch_target (a_tgt),
        .trap          (a_trap),
        .halt          (a_halt),
        .pc_out        (a_pc),
        .pc_plus4      (a_pc4),
        .pc_valid      (a_valid),
        .misaligned    (a_mis),
        .epc           (a_epc),
        .halted        (a_halted),
        .cycle_count   (a_cyc),
        .instret_count (a_ret)
    );

    pc_gen_unit #(
        .WIDTH        (8),
        .RESET_VECTOR (8'hFC),
        .TRAP_VECTOR  (8'h80),
        .CNT_WIDTH    (4),
        .IALIGN       (2)
    ) u_dut_b (
        .clk           (clk),
        .reset         (rst_n),
        .stall         (b_stall),
        .branch_taken  (b_br),
        .branch_target (b_tgt),
        .trap          (b_trap),
        .halt          (b_halt),
        .pc_out        (b_pc),
        .pc_plus4      (b_pc4),
        .pc_valid      (b_valid),
        .misaligned    (b_mis),
        .epc           (b_epc),
        .halted        (b_halted),
        .cycle_count   (b_cyc),
        .instret_count (b_ret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mdl_t mdl_reset(input logic [63:0] rv);
        mdl_t m;
        m.running = 1'b0;
        m.stopped = 1'b0;
        m.mis     = 1'b0;
        m.pc      = rv;
        m.epc     = '0;
        m.cyc     = '0;
        m.ret     = '0;
        return m;
    endfunction

    // One rising edge of the architectural rules, first matching rule wins.
    function automatic mdl_t mdl_step(input mdl_t m, input bit st, input bit br,
                                      input logic [63:0] tgt, input bit tr, input bit hl,
                                      input int pc_bits, input int cnt_bits,
                                      input int ialign, input logic [63:0] trapv);
        logic [63:0] pmask, cmask;
        pmask = (64'd1 << pc_bits) - 64'd1;
        cmask = (cnt_bits >= 64) ? '1 : ((64'd1 << cnt_bits) - 64'd1);
        m.mis = 1'b0;
        if (m.stopped) return m;
        m.cyc = (m.cyc + 64'd1) & cmask;
        if (!m.running) begin
            m.running = 1'b1;
            return m;
        end
        if (hl) begin
            m.running = 1'b0;
            m.stopped = 1'b1;
        end else if (tr) begin
            m.epc = m.pc;
            m.pc  = trapv;
        end else if (st) begin
            // held
        end else if (br && (tgt % ialign) != 0) begin
            m.epc = m.pc;
            m.pc  = trapv;
            m.mis = 1'b1;
        end else begin
            m.pc  = br ? (tgt & pmask) : ((m.pc + 64'd4) & pmask);
            m.ret = (m.ret + 64'd1) & cmask;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_pc_out",    a_pc,     ma.pc);
        check("a_pc_plus4",  a_pc4,    (ma.pc + 64'd4) & 64'hFFFF_FFFF);
        check("a_pc_valid",  a_valid,  ma.running);
        check("a_misaligned",a_mis,    ma.mis);
        check("a_epc",       a_epc,    ma.epc);
        check("a_halted",    a_halted, ma.stopped);
        check("a_cycle",     a_cyc,    ma.cyc);
        check("a_instret",   a_ret,    ma.ret);
        check("b_pc_out",    b_pc,     mb.pc);
        check("b_pc_plus4",  b_pc4,    (mb.pc + 64'd4) & 64'hFF);
        check("b_pc_valid",  b_valid,  mb.running);
        check("b_misaligned",b_mis,    mb.mis);
        check("b_epc",       b_epc,    mb.epc);
        check("b_halted",    b_halted, mb.stopped);
        check("b_cycle",     b_cyc,    mb.cyc);
        check("b_instret",   b_ret,    mb.ret);
    endtask

    always @(negedge clk) compare_all();

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            ma = mdl_step(ma, a_stall, a_br, 64'(a_tgt), a_trap, a_halt, 32, 64, 4, 64'h100);
            mb = mdl_step(mb, b_stall, b_br, 64'(b_tgt), b_trap, b_halt, 8, 4, 2, 64'h80);
        end
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        ma = mdl_reset(64'h0);
        mb = mdl_reset(64'hFC);
    endtask

    initial begin
        {a_stall, a_br, a_trap, a_halt} = '0;
        {b_stall, b_br, b_trap, b_halt} = '0;
        a_tgt = '0;
        b_tgt = '0;
        assert_reset();

        tick();
        tick();
        check("lit_reset_pc", a_pc, 64'h0);
        check("lit_reset_valid", a_valid, 64'h0);
        rst_n = 1'b1;
        check("lit_boot_valid", a_valid, 64'h0);

        tick();
        check("lit_boot_edge_valid", a_valid, 64'h1);
        check("lit_boot_edge_pc", a_pc, 64'h0);
        check("lit_b_boot_pc", b_pc, 64'hFC);
        tick();
        check("lit_b_pc_wrap", b_pc, 64'h00);
        tick();
        tick();
        check("lit_free_pc", a_pc, 64'hC);
        check("lit_free_instret", a_ret, 64'd3);
        check("lit_free_cycle", a_cyc, 64'd4);

        a_br = 1'b1; a_tgt = 32'h8;
        tick();
        a_br = 1'b0;
        check("lit_br8_pc", a_pc, 64'h8);

        a_stall = 1'b1;
        tick();
        tick();
        check("lit_stall_pc", a_pc, 64'h8);
        check("lit_stall_instret", a_ret, 64'd4);

        a_trap = 1'b1;
        tick();
        a_trap = 1'b0; a_stall = 1'b0;
        check("lit_trap_pc", a_pc, 64'h100);
        check("lit_trap_epc", a_epc, 64'h8);
        check("lit_trap_instret", a_ret, 64'd4);

        a_br = 1'b1; a_tgt = 32'h40;
        tick();
        check("lit_br40_pc", a_pc, 64'h40);
        a_tgt = 32'h42;
        tick();
        a_br = 1'b0;
        check("lit_mis_pc", a_pc, 64'h100);
        check("lit_mis_pulse", a_mis, 64'h1);
        check("lit_mis_epc", a_epc, 64'h40);
        check("lit_mis_instret", a_ret, 64'd5);
        tick();
        check("lit_mis_clear", a_mis, 64'h0);
        check("lit_after_mis_pc", a_pc, 64'h104);

        a_br = 1'b1; a_tgt = 32'h10;
        tick();
        a_br = 1'b0;
        a_halt = 1'b1;
        tick();
        a_halt = 1'b0;
        check("lit_halt_halted", a_halted, 64'h1);
        check("lit_halt_valid", a_valid, 64'h0);
        check("lit_halt_pc", a_pc, 64'h10);
        check("lit_halt_cycle", a_cyc, 64'd13);
        check("lit_halt_instret", a_ret, 64'd7);
        a_trap = 1'b1;
        tick();
        a_trap = 1'b0;
        tick();
        tick();
        tick();
        check("lit_halt_trap_pc", a_pc, 64'h10);
        check("lit_halt_trap_epc", a_epc, 64'h40);
        check("lit_halt_cycle_frozen", a_cyc, 64'd13);
        check("lit_b_instret_wrap", b_ret, 64'd0);
        check("lit_b_pc_16", b_pc, 64'h3C);

        #2;
        assert_reset();
        #1;
        check("lit_async_pc", a_pc, 64'h0);
        check("lit_async_halted", a_halted, 64'h0);
        check("lit_async_cycle", a_cyc, 64'h0);
        check("lit_async_instret", a_ret, 64'h0);
        check("lit_async_epc", a_epc, 64'h0);
        check("lit_async_b_pc", b_pc, 64'hFC);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if (!rst_n) begin
                if ($urandom_range(1, 0) == 1) rst_n = 1'b1;
            end else if (((ma.stopped || mb.stopped) && $urandom_range(19, 0) == 0) ||
                         $urandom_range(399, 0) == 0) begin
                assert_reset();
            end
            a_halt  = ($urandom_range(299, 0) == 0);
            a_trap  = ($urandom_range(15, 0) == 0);
            a_stall = ($urandom_range(5, 0) == 0);
            a_br    = ($urandom_range(3, 0) == 0);
            a_tgt   = $urandom;
            if ($urandom_range(1, 0) == 1) a_tgt[1:0] = 2'b00;
            b_halt  = ($urandom_range(299, 0) == 0);
            b_trap  = ($urandom_range(15, 0) == 0);
            b_stall = ($urandom_range(5, 0) == 0);
            b_br    = ($urandom_range(3, 0) == 0);
            b_tgt   = 8'($urandom);
            if ($urandom_range(1, 0) == 1) b_tgt[0] = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
